// File: rtl/udc_config_sequencer.sv
// Host-side sequencer that programs the up/down counter's four registers over its
// async-style bus, optionally reads them back, fires start and waits for end-of-cycle.
module udc_config_sequencer #(
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  input  logic       verify_en,
  inout  wire  [7:0] Din,
  output logic       ncs,
  output logic       nrd,
  output logic       nwr,
  output logic       A1,
  output logic       A0,
  output logic       start,
  input  logic       err_in,
  input  logic       ec_in,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code
);

  localparam int CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_SAMPLE,
    ERR_CHK, START, WAIT_EC, DONE, FAIL
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx, code_nx, addr;
  logic [CW-1:0] cnt;
  logic [7:0]    plr, ulr, llr, ccr, wdata;
  logic          vfy, drv;

  always_comb begin
    case (idx)
      2'd0:    wdata = plr;
      2'd1:    wdata = ulr;
      2'd2:    wdata = llr;
      default: wdata = ccr;
    endcase
  end

  // Data bus is only ours for the three cycles of a write; reads leave it to the counter.
  assign Din  = drv ? wdata : 8'bz;
  assign A1   = addr[1];
  assign A0   = addr[0];

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    code_nx   = fail_code;
    cfg_ready = 1'b0;
    busy      = 1'b1;
    ncs       = 1'b0;
    nrd       = 1'b1;
    nwr       = 1'b1;
    drv       = 1'b0;
    addr      = 2'b00;
    start     = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        ncs       = 1'b1;
        if (cfg_valid) begin
          state_nx = CHECK;
          code_nx  = 2'b00;
        end
      end
      CHECK: begin
        ncs = 1'b1;
        if (plr < llr || plr > ulr || llr > ulr) begin
          state_nx = FAIL;
          code_nx  = 2'b01;
        end else begin
          state_nx = WR_SETUP;
          idx_nx   = 2'd0;
        end
      end
      WR_SETUP: begin
        drv = 1'b1; addr = idx;
        state_nx = WR_STROBE;
      end
      WR_STROBE: begin
        drv = 1'b1; addr = idx; nwr = 1'b0;
        state_nx = WR_HOLD;
      end
      WR_HOLD: begin
        drv = 1'b1; addr = idx;
        idx_nx = idx + 2'd1;
        if (idx == 2'd3) state_nx = vfy ? RD_STROBE : ERR_CHK;
        else             state_nx = WR_SETUP;
      end
      RD_STROBE: begin
        nrd = 1'b0; addr = idx;
        state_nx = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        nrd = 1'b0; addr = idx;
        idx_nx = idx + 2'd1;
        if (Din != wdata) begin
          state_nx = FAIL;
          code_nx  = 2'b10;
          idx_nx   = 2'd0;
        end else if (idx == 2'd3) begin
          state_nx = ERR_CHK;
        end else begin
          state_nx = RD_STROBE;
        end
      end
      ERR_CHK: begin
        if (cnt == CW'(1)) begin
          if (err_in) begin
            state_nx = FAIL;
            code_nx  = 2'b01;
          end else begin
            state_nx = START;
          end
        end
      end
      START: begin
        start = 1'b1;
        if (cnt == CW'(START_CYCLES - 1)) state_nx = (ccr == 8'd0) ? DONE : WAIT_EC;
      end
      WAIT_EC: begin
        // ec_in is checked first so a coincident timeout still completes cleanly.
        if (ec_in) begin
          state_nx = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx = FAIL;
          code_nx  = 2'b11;
        end
      end
      DONE: begin
        ncs = 1'b1; done = 1'b1;
        state_nx = IDLE;
      end
      FAIL: begin
        ncs = 1'b1; fail = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      fail_code <= 2'b00;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      fail_code <= code_nx;
      cnt       <= (state_nx != state) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plr <= 8'd0; ulr <= 8'd0; llr <= 8'd0; ccr <= 8'd0; vfy <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      plr <= cfg_plr; ulr <= cfg_ulr; llr <= cfg_llr; ccr <= cfg_ccr; vfy <= verify_en;
    end
  end

endmodule

// File: tb/tb_udc_config_sequencer.sv
// Directed bench for udc_config_sequencer: a counter register model answers reads,
// a second instance with TIMEOUT=8 exercises the end-of-cycle timeout.
module tb_udc_config_sequencer;

  logic       clk, reset, cfg_valid, verify_en, err_in, ec_in, corrupt;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  wire  [7:0] din, din_t;
  logic       cfg_ready, ncs, nrd, nwr, a1, a0, start, busy, done, fail;
  logic [1:0] fail_code;
  logic       cfg_ready_t, ncs_t, nrd_t, nwr_t, a1_t, a0_t, start_t, busy_t, done_t, fail_t;
  logic [1:0] fail_code_t;

  logic [7:0] mreg [4];
  logic [7:0] rd_val;
  int         n_acc, n_start, n_tests, n_fail;

  udc_config_sequencer u_dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .verify_en(verify_en), .Din(din), .ncs(ncs), .nrd(nrd), .nwr(nwr), .A1(a1), .A0(a0),
    .start(start), .err_in(err_in), .ec_in(ec_in), .busy(busy), .done(done), .fail(fail),
    .fail_code(fail_code)
  );

  udc_config_sequencer #(.START_CYCLES(1), .TIMEOUT(8)) u_dut_t (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_t),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .verify_en(1'b0), .Din(din_t), .ncs(ncs_t), .nrd(nrd_t), .nwr(nwr_t), .A1(a1_t), .A0(a0_t),
    .start(start_t), .err_in(err_in), .ec_in(ec_in), .busy(busy_t), .done(done_t), .fail(fail_t),
    .fail_code(fail_code_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: latches writes on the strobe cycle, answers reads (ULR optionally corrupted).
  always_comb begin
    rd_val = mreg[{a1, a0}];
    if (corrupt && {a1, a0} == 2'd1) rd_val = 8'd199;
  end
  assign din = (!ncs && !nrd) ? rd_val : 8'bz;

  initial begin
    for (int i = 0; i < 4; i++) mreg[i] = 8'd0;
    n_acc   = 0;
    n_start = 0;
  end

  always @(posedge clk) begin
    if (!ncs && !nwr) mreg[{a1, a0}] <= din;
    if (cfg_valid && cfg_ready) n_acc <= n_acc + 1;
    if (start) n_start <= n_start + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; cfg_valid = 1'b0; ec_in = 1'b0; err_in = 1'b0; corrupt = 1'b0;
    verify_en = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
  endtask

  // Presents a request at a negedge; returns at the negedge where the DUT sits in CHECK.
  task automatic send(input logic [7:0] p, u, l, c, input logic v, input logic hold = 1'b0);
    cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c; verify_en = v;
    cfg_valid = 1'b1;
    tick();
    if (!hold) cfg_valid = 1'b0;
  endtask

  logic [7:0] wd [4];
  int         acc0, st0;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0; cfg_valid = 1'b0; ec_in = 1'b0; err_in = 1'b0; corrupt = 1'b0;
    verify_en = 1'b0;
    cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
    tick();
    // order: cfg_ready,busy,ncs,nrd,nwr,A1,A0,start,done,fail,fail_code
    chk("reset_state", {cfg_ready, busy, ncs, nrd, nwr, a1, a0, start, done, fail, fail_code},
        12'b1011_1000_0000);

    // Nominal programming sequence with end-of-cycle after ~50 cycles
    do_reset();
    wd[0] = 8'd20; wd[1] = 8'd200; wd[2] = 8'd10; wd[3] = 8'd2;
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b0);
    chk("check_st", {busy, ncs, cfg_ready}, 3'b110);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) begin
        tick();
        chk($sformatf("wr%0d_%0d", i, j), {ncs, nrd, nwr, a1, a0, din},
            {1'b0, 1'b1, (j != 1), 2'(i), wd[i]});
      end
    tick(); chk("errchk1", {ncs, start, busy}, 3'b001);
    tick(); chk("errchk2", {ncs, start, busy}, 3'b001);
    tick(); chk("start_pulse", {start, ncs}, 2'b10);
    tick(); chk("wait_first", {start, done, busy, ncs}, 4'b0010);
    tick(49); chk("wait_49", {done, fail, busy}, 3'b001);
    ec_in = 1'b1;
    tick(); chk("done_pulse", {done, fail, fail_code, busy}, 5'b10001);
    ec_in = 1'b0;
    tick(); chk("back_idle", {done, busy, cfg_ready, ncs}, 4'b0011);
    chk("regs_written", {mreg[0], mreg[1], mreg[2], mreg[3]}, {8'd20, 8'd200, 8'd10, 8'd2});

    // Range violation: plr below llr
    do_reset();
    send(8'd5, 8'd200, 8'd10, 8'd2, 1'b0);
    chk("range_check", {ncs, fail}, 2'b10);
    tick(); chk("range_fail", {fail, fail_code, ncs}, 4'b1011);
    tick(); chk("range_hold", {fail, busy, fail_code}, 4'b0001);
    // Equal limits are legal; new request clears fail_code; ccr=0 skips WAIT_EC
    send(8'd10, 8'd10, 8'd10, 8'd0, 1'b0);
    chk("code_cleared", fail_code, 2'b00);
    tick(); chk("eq_ok", {ncs, fail, a1, a0}, 4'b0000);
    tick(14); chk("ccr0_start", start, 1'b1);
    tick(); chk("ccr0_done", {done, start, fail}, 3'b100);

    // Verify enabled, clean readback
    do_reset();
    send(8'd20, 8'd200, 8'd10, 8'd0, 1'b1);
    tick(13); chk("rd0_strobe", {ncs, nrd, nwr, a1, a0, din}, {5'b00100, 8'd20});
    tick(10); chk("vfy_start", start, 1'b1);
    tick(); chk("vfy_done", {done, fail, fail_code}, 4'b1000);

    // Verify enabled, ULR reads back 199
    do_reset();
    corrupt = 1'b1;
    st0 = n_start;
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b1);
    tick(16); chk("rd1_sample", {nrd, a1, a0, din}, {3'b001, 8'd199});
    tick(); chk("vfy_fail", {fail, fail_code, nrd, start}, 5'b11010);
    tick(); chk("vfy_no_start", n_start - st0, 0);
    corrupt = 1'b0;

    // err_in on the second ERR_CHK cycle
    do_reset();
    err_in = 1'b1;
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b0);
    tick(14); chk("err_chk2", {busy, fail}, 2'b10);
    tick(); chk("err_fail", {fail, fail_code, start}, 4'b1010);
    err_in = 1'b0;

    // Timeout on the TIMEOUT=8 instance; the default instance keeps waiting
    do_reset();
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b0);
    tick(15); chk("t_start", start_t, 1'b1);
    tick(8);  chk("t_wait8", {fail_t, busy_t}, 2'b01);
    tick();   chk("t_fail", {fail_t, fail_code_t}, 3'b111);
    chk("t_default_waits", {busy, fail}, 2'b10);

    // ec_in in the last WAIT_EC cycle beats the timeout
    do_reset();
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b0);
    tick(23);
    ec_in = 1'b1;
    tick(); chk("ec_wins", {done_t, fail_t, fail_code_t}, 4'b1000);
    ec_in = 1'b0;

    // Reset during the LLR strobe, then restart from PLR
    do_reset();
    send(8'd20, 8'd200, 8'd10, 8'd2, 1'b0);
    tick(8); chk("llr_strobe", {nwr, a1, a0, din}, {3'b010, 8'd10});
    #1 reset = 1'b0;
    #1 chk("rst_async", {nwr, ncs, nrd, busy, cfg_ready, start, a1, a0}, 8'b11101000);
    tick(); reset = 1'b1;
    tick();
    send(8'd33, 8'd200, 8'd10, 8'd0, 1'b0);
    tick(); chk("restart_plr", {ncs, nwr, a1, a0, din}, {4'b0100, 8'd33});

    // cfg_valid held high while busy; inputs changed after handshake
    do_reset();
    acc0 = n_acc;
    send(8'd44, 8'd200, 8'd10, 8'd0, 1'b0, 1'b1);
    cfg_plr = 8'd99; cfg_ccr = 8'd5;
    tick(16); chk("hold_done", {done, fail}, 2'b10);
    cfg_valid = 1'b0;
    tick(); chk("one_accept", n_acc - acc0, 1);
    chk("plr_latched", mreg[0], 8'd44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/udc_config_sequencer.md
UDC_CONFIG_SEQUENCER -- requirements
Module: udc_config_sequencer

Interface
REQ-001 SHALL have parameter START_CYCLES, default 1, giving the number of clk cycles start is held high.
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum clk cycles spent in WAIT_EC before fail.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cfg_valid input 1 and cfg_ready output 1, forming the host request handshake.
REQ-006 SHALL have ports cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  input  8 each  preload, upper limit, lower limit and cycle count values.
REQ-007 SHALL have port verify_en  input  1  enables readback compare after the writes.
REQ-008 SHALL have port Din  inout  8  counter data bus; driven only while nwr=0 or in write setup/hold, else 8'bz.
REQ-009 SHALL have ports ncs, nrd, nwr output 1 each (active-low) and A1, A0 output 1 each, forming the counter bus controls.
REQ-010 SHALL have port start  output  1  start pulse to the counter's start_in.
REQ-011 SHALL have ports err_in, ec_in  input  1 each  counter err and end-of-cycle flags.
REQ-012 SHALL have ports busy, done, fail output 1 each and fail_code output 2, forming host status.

Function
REQ-013 SHALL use states IDLE, CHECK, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_SAMPLE, ERR_CHK, START, WAIT_EC, DONE and FAIL.
REQ-014 SHALL assert cfg_ready only in IDLE, and SHALL latch all cfg_* and verify_en on the posedge where cfg_valid=1 and cfg_ready=1, then go to CHECK.
REQ-015 SHALL ignore changes to cfg_* after the handshake, and SHALL ignore cfg_valid while busy.
REQ-016 SHALL go from CHECK to FAIL with fail_code=01 and no bus activity if plr<llr, plr>ulr or llr>ulr (unsigned 8-bit compares); otherwise SHALL go to WR_SETUP with index 0.
REQ-017 SHALL, while busy, hold ncs=0 continuously from WR_SETUP through WAIT_EC; ncs SHALL be 1 in IDLE, CHECK, DONE and FAIL.
REQ-018 SHALL run each register write as exactly 3 cycles, SETUP -> STROBE -> HOLD: {A1,A0} and Din stable in all three cycles, nwr=0 only in STROBE, nrd=1 throughout.
REQ-019 SHALL use write order and addresses PLR=00, ULR=01, LLR=10, CCR=11, with each register written exactly once per request, so 4 writes take 12 cycles.
REQ-020 SHALL, after the CCR write with verify_en=1, read back each register in the same order; each read is RD_STROBE then RD_SAMPLE, nrd=0 in both cycles, Din released, and Din sampled at the end of RD_SAMPLE.
REQ-021 SHALL go to FAIL with fail_code=10 on any readback mismatch, after releasing nrd=1 first.
REQ-022 SHALL spend exactly 2 cycles in ERR_CHK after the writes (and reads, if enabled), going to FAIL with fail_code=01 if err_in=1 on the second cycle, else to START.
REQ-023 SHALL hold start=1 for exactly START_CYCLES cycles in START, then drive start=0.
REQ-024 SHALL go directly from START to DONE if the latched ccr=0; otherwise SHALL go to WAIT_EC.
REQ-025 SHALL, in WAIT_EC, go to DONE on the first cycle with ec_in=1, and SHALL go to FAIL with fail_code=11 if TIMEOUT cycles elapse without it; ec_in SHALL be ignored in all other states.
REQ-026 SHALL pulse done (or fail) high for exactly one cycle in DONE (or FAIL), then return to IDLE.
REQ-027 SHALL hold fail_code until the next accepted request, which clears it to 00.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL let ec_in win if ec_in=1 and the timeout expire in the same cycle (DONE, not FAIL).

Reset
REQ-030 SHALL, on reset=0 at any time (including mid-write or mid-wait), immediately force state=IDLE, ncs=nrd=nwr=1, A1=A0=0, Din=8'bz, start=0, busy=done=fail=0, fail_code=00 and cfg_ready=1.
REQ-031 SHALL resume normal operation on the first posedge after reset returns to 1, with no partial bus cycle completed.

Verification
REQ-032 Bench SHALL cover: plr=20, ulr=200, llr=10, ccr=2, verify_en=0 -> 12 write cycles at addresses 00,01,10,11 with data 20,200,10,2; 2 ERR_CHK cycles; 1 start cycle; ec_in after 50 cycles -> done pulse, fail_code=00.
REQ-033 Bench SHALL cover: plr=5, llr=10, ulr=200 -> fail pulse 1 cycle after handshake, fail_code=01, ncs never low.
REQ-034 Bench SHALL cover: verify_en=1 with a model returning ULR=199 -> fail_code=10 after the ULR read; no start pulse.
REQ-035 Bench SHALL cover: ccr=0 -> done the cycle after START with no wait; TIMEOUT=8 and ec_in held 0 -> fail_code=11 after 8 WAIT_EC cycles.
REQ-036 Bench SHALL cover: reset=0 during the WR_STROBE of the LLR write -> nwr=1, ncs=1 and Din=z in the same cycle; a new request afterwards restarts from the PLR write.
REQ-037 Bench SHALL cover: cfg_valid held high while busy -> exactly one request accepted.
